// File: rtl/y_drop_controller.sv
// Vertical-position engine for the falling tower block: auto-drop, landing, floor tracking, full flag.
// Optional accelerated drop is enabled by defining Y_FAST_DROP_EN (adds the fast_drop_i port).
//   state      | meaning
//   ST_IDLE    | waiting for start/load
//   ST_FALLING | block moving down one STEP per tick
//   ST_FULL    | tower reached the top, frozen until reset
module y_drop_controller #(
  parameter int Y_W      = 7,
  parameter int Y_INIT   = 104,
  parameter int Y_TOP    = 0,
  parameter int BLOCK_H  = 16,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 833333
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start_i,
  input  logic           load_i,
  input  logic [Y_W-1:0] new_y_i,
`ifdef Y_FAST_DROP_EN
  input  logic           fast_drop_i,
`endif
  output logic [Y_W-1:0] curr_y_o,
  output logic [Y_W-1:0] floor_y_o,
  output logic           falling_o,
  output logic           landed_o,
  output logic           full_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FALLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FAST_DIV = ((TICK_DIV / 4) >= 1) ? (TICK_DIV / 4) : 1;

  // Two guard bits: one for carry on curr_y+STEP, one sign bit for target-BLOCK_H.
  localparam int W = Y_W + 2;
  localparam logic signed [W-1:0] BLOCK_H_S = W'(BLOCK_H);
  localparam logic signed [W-1:0] STEP_S    = W'(STEP);
  localparam logic signed [W-1:0] Y_TOP_S   = W'(Y_TOP);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_m1;
  logic [Y_W-1:0]   curr_q, curr_d;
  logic [Y_W-1:0]   floor_q, floor_d;
  logic             falling_q;
  logic             landed_q, landed_d;
  logic             full_q, full_d;
  logic             tick;

  logic signed [W-1:0] target_s;
  logic signed [W-1:0] next_y_s;
  logic signed [W-1:0] above_s;
  logic signed [W-1:0] new_y_s;

`ifdef Y_FAST_DROP_EN
  assign period_m1 = fast_drop_i ? CNT_W'(FAST_DIV - 1) : CNT_W'(TICK_DIV - 1);
`else
  assign period_m1 = CNT_W'(TICK_DIV - 1);
`endif

  // >= rather than == so a shortened period mid-count fires on the next edge.
  assign tick = (cnt_q >= period_m1);

  assign target_s = $signed({2'b00, floor_q}) - BLOCK_H_S;
  assign next_y_s = $signed({2'b00, curr_q}) + STEP_S;
  assign above_s  = target_s - BLOCK_H_S;
  assign new_y_s  = $signed({2'b00, new_y_i});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    curr_d   = curr_q;
    floor_d  = floor_q;
    landed_d = 1'b0;
    full_d   = full_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          curr_d  = Y_W'(Y_TOP);
          cnt_d   = '0;
          state_d = ST_FALLING;
        end else if (load_i) begin
          curr_d = (new_y_s < target_s) ? new_y_i : target_s[Y_W-1:0];
        end
      end

      ST_FALLING: begin
        if (tick) begin
          cnt_d = '0;
          if (next_y_s < target_s) begin
            curr_d = next_y_s[Y_W-1:0];
          end else begin
            curr_d   = target_s[Y_W-1:0];
            floor_d  = target_s[Y_W-1:0];
            landed_d = 1'b1;
            if (above_s < Y_TOP_S) begin
              full_d  = 1'b1;
              state_d = ST_FULL;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FULL: begin
        state_d = ST_FULL;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      curr_q    <= Y_W'(Y_TOP);
      floor_q   <= Y_W'(Y_INIT);
      falling_q <= 1'b0;
      landed_q  <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      curr_q    <= curr_d;
      floor_q   <= floor_d;
      falling_q <= (state_d == ST_FALLING);
      landed_q  <= landed_d;
      full_q    <= full_d;
    end
  end

  assign curr_y_o  = curr_q;
  assign floor_y_o = floor_q;
  assign falling_o = falling_q;
  assign landed_o  = landed_q;
  assign full_o    = full_q;

endmodule
